issue_dispatcher: RTL and testbench

Issue-stage controller that sequences the instruction decoder between the instruction queue and the out-of-order back end. It pops one instruction at a time, holds it while the combinational decoder resolves it, and waits until a ROB entry and a slot in the correct station (RS or LSB) are free. It then allocates the ROB tag, renames rd in the register file, and emits a registered issue packet carrying resolved operands or producer tags. It sits between the instruction queue and the ROB/RS/LSB/register file.

---
 rtl/issue_dispatcher.sv | 181 ++++++++++++++++++
 tb/tb_issue_dispatcher.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_dispatcher.sv
// Issue-stage controller: holds one queue instruction while it is decoded and
// issues it to the RS or LSB once a ROB entry and a station slot are free.
`ifndef OPENUM_NOP
`define OPENUM_NOP 6'd0
`endif

module issue_dispatcher #(
   parameter int ROB_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              rollback,
   input  logic              iq_valid,
   input  logic [31:0]       iq_inst,
   input  logic [31:0]       iq_pc,
   output logic              iq_pop,
   output logic [31:0]       dec_inst,
   input  logic [5:0]        dec_openum,
   input  logic [4:0]        dec_rd,
   input  logic [4:0]        dec_rs1,
   input  logic [4:0]        dec_rs2,
   input  logic [31:0]       dec_imm,
   input  logic              dec_is_store,
   input  logic              rob_full,
   input  logic              rs_full,
   input  logic              lsb_full,
   input  logic [ROB_W-1:0]  rob_free_tag,
   output logic              rob_alloc,
   input  logic              rf_rs1_busy,
   input  logic [ROB_W-1:0]  rf_rs1_tag,
   input  logic [31:0]       rf_rs1_val,
   input  logic              rf_rs2_busy,
   input  logic [ROB_W-1:0]  rf_rs2_tag,
   input  logic [31:0]       rf_rs2_val,
   output logic              rf_rename_en,
   output logic [4:0]        rf_rename_rd,
   output logic [ROB_W-1:0]  rf_rename_tag,
   output logic              iss_valid,
   output logic              iss_to_lsb,
   output logic [5:0]        iss_openum,
   output logic [4:0]        iss_rd,
   output logic [31:0]       iss_imm,
   output logic [31:0]       iss_pc,
   output logic [ROB_W-1:0]  iss_tag,
   output logic              iss_q1_valid,
   output logic [ROB_W-1:0]  iss_q1,
   output logic [31:0]       iss_v1,
   output logic              iss_q2_valid,
   output logic [ROB_W-1:0]  iss_q2,
   output logic [31:0]       iss_v2,
   output logic [15:0]       drop_cnt
);

   localparam int OPND_W = ROB_W + 33;

   typedef enum logic {EMPTY, HELD} state_t;

   state_t             state_p0, state_nx;
   logic [31:0]        inst_p0, pc_p0;
   logic [15:0]        drop_cnt_p0;

   logic               vld_p1, to_lsb_p1, q1_valid_p1, q2_valid_p1;
   logic [5:0]         openum_p1;
   logic [4:0]         rd_p1;
   logic [31:0]        imm_p1, pc_p1, v1_p1, v2_p1;
   logic [ROB_W-1:0]   tag_p1, q1_p1, q2_p1;

   logic [6:0]         opcode;
   logic               held, is_nop, to_lsb, tgt_full, fire, drop;
   logic               rs1_used, rs2_used;
   logic [OPND_W-1:0]  opnd1, opnd2;

   // Operand source: {q_valid, q, v}; unused or x0 operands carry nothing.
   function automatic logic [OPND_W-1:0] resolve_opnd(
      input logic             used,
      input logic [4:0]       idx,
      input logic             busy,
      input logic [ROB_W-1:0] tag,
      input logic [31:0]      val
   );
      logic [OPND_W-1:0] r;
      r = '0;
      if (used && idx != 5'd0) begin
         if (busy) r = {1'b1, tag, 32'd0};
         else      r = {1'b0, {ROB_W{1'b0}}, val};
      end
      return r;
   endfunction

   assign held     = (state_p0 == HELD);
   assign dec_inst = held ? inst_p0 : 32'd0;
   assign opcode   = dec_inst[6:0];
   assign is_nop   = (dec_openum == `OPENUM_NOP);
   assign to_lsb   = (opcode == 7'b0000011) || dec_is_store;
   assign tgt_full = to_lsb ? lsb_full : rs_full;
   assign rs1_used = !(opcode == 7'b0110111 || opcode == 7'b0010111 || opcode == 7'b1101111);
   assign rs2_used = (opcode == 7'b1100011) || (opcode == 7'b0100011) || (opcode == 7'b0110011);
   assign opnd1    = resolve_opnd(rs1_used, dec_rs1, rf_rs1_busy, rf_rs1_tag, rf_rs1_val);
   assign opnd2    = resolve_opnd(rs2_used, dec_rs2, rf_rs2_busy, rf_rs2_tag, rf_rs2_val);

   always_comb begin
      fire          = held && !rollback && rdy && !is_nop && !rob_full && !tgt_full;
      drop          = held && rdy && !rollback && is_nop;
      iq_pop        = rdy && !rollback && iq_valid && (!held || fire || drop);
      rob_alloc     = fire;
      rf_rename_en  = fire && (dec_rd != 5'd0);
      rf_rename_rd  = dec_rd;
      rf_rename_tag = rob_free_tag;
      state_nx      = state_p0;
      if (rollback)          state_nx = EMPTY;
      else if (!rdy)         state_nx = state_p0;
      else if (iq_pop)       state_nx = HELD;
      else if (fire || drop) state_nx = EMPTY;
   end

   // p0: held instruction and control state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_p0    <= EMPTY;
         inst_p0     <= 32'd0;
         pc_p0       <= 32'd0;
         drop_cnt_p0 <= 16'd0;
      end else begin
         state_p0 <= state_nx;
         if (iq_pop) begin
            inst_p0 <= iq_inst;
            pc_p0   <= iq_pc;
         end
         if (drop && drop_cnt_p0 != 16'hFFFF)
            drop_cnt_p0 <= drop_cnt_p0 + 16'd1;
      end
   end

   // p1: registered issue packet
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         to_lsb_p1   <= 1'b0;
         openum_p1   <= '0;
         rd_p1       <= '0;
         imm_p1      <= '0;
         pc_p1       <= '0;
         tag_p1      <= '0;
         q1_valid_p1 <= 1'b0;
         q1_p1       <= '0;
         v1_p1       <= '0;
         q2_valid_p1 <= 1'b0;
         q2_p1       <= '0;
         v2_p1       <= '0;
      end else begin
         vld_p1 <= fire;
         if (fire) begin
            to_lsb_p1                          <= to_lsb;
            openum_p1                          <= dec_openum;
            rd_p1                              <= dec_rd;
            imm_p1                             <= dec_imm;
            pc_p1                              <= pc_p0;
            tag_p1                             <= rob_free_tag;
            {q1_valid_p1, q1_p1, v1_p1}        <= opnd1;
            {q2_valid_p1, q2_p1, v2_p1}        <= opnd2;
         end
      end
   end

   assign iss_valid    = vld_p1;
   assign iss_to_lsb   = to_lsb_p1;
   assign iss_openum   = openum_p1;
   assign iss_rd       = rd_p1;
   assign iss_imm      = imm_p1;
   assign iss_pc       = pc_p1;
   assign iss_tag      = tag_p1;
   assign iss_q1_valid = q1_valid_p1;
   assign iss_q1       = q1_p1;
   assign iss_v1       = v1_p1;
   assign iss_q2_valid = q2_valid_p1;
   assign iss_q2       = q2_p1;
   assign iss_v2       = v2_p1;
   assign drop_cnt     = drop_cnt_p0;

endmodule

// File: tb/tb_issue_dispatcher.sv
// Directed bench for issue_dispatcher with a small RV32 decoder stand-in.
module tb_issue_dispatcher;

   localparam int ROB_W = 4;
   localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
   localparam logic [31:0] I_ADD  = 32'h00108133;  // add  x2,x1,x1
   localparam logic [31:0] I_SW   = 32'h0020A223;  // sw   x2,4(x1)
   localparam logic [31:0] I_LUI  = 32'h123451B7;  // lui  x3,0x12345

   logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, rollback = 1'b0;
   logic iq_valid = 1'b0;
   logic [31:0] iq_inst = '0, iq_pc = '0;
   logic iq_pop;
   logic [31:0] dec_inst;
   logic [5:0] dec_openum;
   logic [4:0] dec_rd, dec_rs1, dec_rs2;
   logic [31:0] dec_imm;
   logic dec_is_store;
   logic rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
   logic [ROB_W-1:0] rob_free_tag = '0;
   logic rob_alloc;
   logic rf_rs1_busy = 1'b0, rf_rs2_busy = 1'b0;
   logic [ROB_W-1:0] rf_rs1_tag = '0, rf_rs2_tag = '0;
   logic [31:0] rf_rs1_val = '0, rf_rs2_val = '0;
   logic rf_rename_en;
   logic [4:0] rf_rename_rd;
   logic [ROB_W-1:0] rf_rename_tag;
   logic iss_valid, iss_to_lsb, iss_q1_valid, iss_q2_valid;
   logic [5:0] iss_openum;
   logic [4:0] iss_rd;
   logic [31:0] iss_imm, iss_pc, iss_v1, iss_v2;
   logic [ROB_W-1:0] iss_tag, iss_q1, iss_q2;
   logic [15:0] drop_cnt;

   int n_chk = 0, n_pass = 0;

   issue_dispatcher #(.ROB_W(ROB_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_pop(iq_pop),
      .dec_inst(dec_inst), .dec_openum(dec_openum), .dec_rd(dec_rd),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_imm(dec_imm), .dec_is_store(dec_is_store),
      .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
      .rob_free_tag(rob_free_tag), .rob_alloc(rob_alloc),
      .rf_rs1_busy(rf_rs1_busy), .rf_rs1_tag(rf_rs1_tag), .rf_rs1_val(rf_rs1_val),
      .rf_rs2_busy(rf_rs2_busy), .rf_rs2_tag(rf_rs2_tag), .rf_rs2_val(rf_rs2_val),
      .rf_rename_en(rf_rename_en), .rf_rename_rd(rf_rename_rd), .rf_rename_tag(rf_rename_tag),
      .iss_valid(iss_valid), .iss_to_lsb(iss_to_lsb), .iss_openum(iss_openum),
      .iss_rd(iss_rd), .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_tag(iss_tag),
      .iss_q1_valid(iss_q1_valid), .iss_q1(iss_q1), .iss_v1(iss_v1),
      .iss_q2_valid(iss_q2_valid), .iss_q2(iss_q2), .iss_v2(iss_v2),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   // Decoder stand-in: the all-zero word decodes to the NOP openum, everything else to 1.
   always_comb begin
      logic [6:0] op;
      op           = dec_inst[6:0];
      dec_openum   = (dec_inst == 32'd0) ? 6'd0 : 6'd1;
      dec_is_store = (op == 7'b0100011);
      dec_rd       = (op == 7'b0100011 || op == 7'b1100011) ? 5'd0 : dec_inst[11:7];
      dec_rs1      = dec_inst[19:15];
      dec_rs2      = dec_inst[24:20];
      dec_imm      = 32'd0;
      case (op)
         7'b0010011, 7'b0000011: dec_imm = {{20{dec_inst[31]}}, dec_inst[31:20]};
         7'b0100011:             dec_imm = {{20{dec_inst[31]}}, dec_inst[31:25], dec_inst[11:7]};
         7'b0110111, 7'b0010111: dec_imm = {dec_inst[31:12], 12'd0};
         default:                dec_imm = 32'd0;
      endcase
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      // reset state
      tick(); tick();
      check_eq("rst_iss_valid", iss_valid, 0);
      check_eq("rst_dec_inst", dec_inst, 0);
      check_eq("rst_drop_cnt", drop_cnt, 0);
      check_eq("rst_iss_tag", iss_tag, 0);
      check_eq("rst_alloc", rob_alloc, 0);
      rst = 1'b0;

      // back-to-back ADDI / ADD
      iq_valid = 1; iq_inst = I_ADDI; iq_pc = 32'h100; rob_free_tag = 0;
      settle();
      check_eq("b2b_pop0", iq_pop, 1);
      check_eq("b2b_alloc_empty", rob_alloc, 0);
      tick();
      iq_inst = I_ADD; iq_pc = 32'h104;
      settle();
      check_eq("b2b_dec_inst", dec_inst, I_ADDI);
      check_eq("b2b_alloc0", rob_alloc, 1);
      check_eq("b2b_ren0", {rf_rename_en, rf_rename_rd, rf_rename_tag}, {1'b1, 5'd1, 4'd0});
      check_eq("b2b_pop1", iq_pop, 1);
      tick();
      check_eq("b2b_iss0_valid", iss_valid, 1);
      check_eq("b2b_iss0_pkt", {iss_rd, iss_tag, iss_to_lsb, iss_openum}, {5'd1, 4'd0, 1'b0, 6'd1});
      check_eq("b2b_iss0_imm", iss_imm, 5);
      check_eq("b2b_iss0_pc", iss_pc, 32'h100);
      check_eq("b2b_iss0_ops", {iss_q1_valid, iss_v1, iss_q2_valid, iss_v2}, 0);
      iq_valid = 0; rob_free_tag = 1;
      rf_rs1_busy = 1; rf_rs1_tag = 0; rf_rs2_busy = 1; rf_rs2_tag = 0;
      settle();
      check_eq("b2b_alloc1", rob_alloc, 1);
      check_eq("b2b_ren1", {rf_rename_en, rf_rename_rd, rf_rename_tag}, {1'b1, 5'd2, 4'd1});
      check_eq("b2b_nopop", iq_pop, 0);
      tick();
      check_eq("b2b_iss1_valid", iss_valid, 1);
      check_eq("b2b_iss1_tag", {iss_rd, iss_tag}, {5'd2, 4'd1});
      check_eq("b2b_iss1_q", {iss_q1_valid, iss_q1, iss_q2_valid, iss_q2}, {1'b1, 4'd0, 1'b1, 4'd0});
      rf_rs1_busy = 0; rf_rs2_busy = 0;
      tick();
      check_eq("b2b_pulse_end", iss_valid, 0);

      // store stalled on full LSB, then LUI popped as the store fires
      iq_valid = 1; iq_inst = I_SW; iq_pc = 32'h200; lsb_full = 1; rob_free_tag = 2;
      rf_rs1_val = 32'h1000; rf_rs2_val = 32'h55;
      tick();
      iq_inst = I_LUI; iq_pc = 32'h204;
      for (int i = 0; i < 3; i++) begin
         settle();
         check_eq($sformatf("sw_stall_pop%0d", i), iq_pop, 0);
         check_eq($sformatf("sw_stall_alloc%0d", i), rob_alloc, 0);
         check_eq($sformatf("sw_stall_inst%0d", i), dec_inst, I_SW);
         tick();
         check_eq($sformatf("sw_stall_iss%0d", i), iss_valid, 0);
      end
      lsb_full = 0;
      settle();
      check_eq("sw_alloc", rob_alloc, 1);
      check_eq("sw_no_rename", rf_rename_en, 0);
      check_eq("sw_pop_next", iq_pop, 1);
      tick();
      check_eq("sw_iss", {iss_valid, iss_to_lsb, iss_rd, iss_tag}, {1'b1, 1'b1, 5'd0, 4'd2});
      check_eq("sw_v1", iss_v1, 32'h1000);
      check_eq("sw_v2", iss_v2, 32'h55);
      check_eq("sw_imm", iss_imm, 4);
      iq_valid = 0; rob_free_tag = 3;
      rf_rs1_busy = 1; rf_rs1_tag = 5; rf_rs2_busy = 1; rf_rs2_tag = 6;
      rf_rs1_val = 32'hDEAD; rf_rs2_val = 32'hBEEF;
      settle();
      check_eq("lui_ren", {rf_rename_en, rf_rename_rd, rf_rename_tag}, {1'b1, 5'd3, 4'd3});
      tick();
      check_eq("lui_iss", {iss_valid, iss_to_lsb, iss_rd, iss_tag}, {1'b1, 1'b0, 5'd3, 4'd3});
      check_eq("lui_imm", iss_imm, 32'h12345000);
      check_eq("lui_ops", {iss_q1_valid, iss_v1, iss_q2_valid, iss_v2}, 0);
      check_eq("lui_pc", iss_pc, 32'h204);
      rf_rs1_busy = 0; rf_rs2_busy = 0;

      // ROB full with RS free
      iq_valid = 1; iq_inst = I_ADDI; iq_pc = 32'h240; rob_full = 1; rob_free_tag = 4;
      tick();
      iq_valid = 0;
      for (int i = 0; i < 2; i++) begin
         settle();
         check_eq($sformatf("robf_alloc%0d", i), rob_alloc, 0);
         tick();
         check_eq($sformatf("robf_iss%0d", i), iss_valid, 0);
      end
      rob_full = 0;
      settle();
      check_eq("robf_release_alloc", rob_alloc, 1);
      tick();
      check_eq("robf_iss", {iss_valid, iss_tag}, {1'b1, 4'd4});
      tick();
      check_eq("robf_pulse_end", iss_valid, 0);

      // rollback while held with the queue offering another instruction
      iq_valid = 1; iq_inst = I_ADD; iq_pc = 32'h280; rob_free_tag = 5;
      tick();
      iq_inst = I_ADDI; rollback = 1;
      settle();
      check_eq("rb_pop", iq_pop, 0);
      check_eq("rb_alloc", rob_alloc, 0);
      check_eq("rb_rename", rf_rename_en, 0);
      tick();
      rollback = 0;
      settle();
      check_eq("rb_empty", dec_inst, 0);
      check_eq("rb_iss", iss_valid, 0);
      check_eq("rb_pop_after", iq_pop, 1);
      iq_valid = 0;

      // NOP drop with the next instruction popped in the same cycle
      iq_valid = 1; iq_inst = 32'd0; iq_pc = 32'h2C0;
      tick();
      iq_inst = I_ADDI; iq_pc = 32'h300;
      settle();
      check_eq("drop_alloc", rob_alloc, 0);
      check_eq("drop_rename", rf_rename_en, 0);
      check_eq("drop_pop", iq_pop, 1);
      tick();
      check_eq("drop_cnt", drop_cnt, 1);
      check_eq("drop_iss", iss_valid, 0);
      check_eq("drop_next_held", dec_inst, I_ADDI);
      iq_valid = 0; rob_free_tag = 6;
      tick();
      check_eq("drop_next_iss", {iss_valid, iss_tag, iss_pc}, {1'b1, 4'd6, 32'h300});

      // rdy low freezes, then async reset mid-stall
      iq_valid = 1; iq_inst = I_ADD; iq_pc = 32'h340;
      tick();
      iq_inst = I_LUI; rdy = 0;
      settle();
      check_eq("frz_alloc", rob_alloc, 0);
      check_eq("frz_pop", iq_pop, 0);
      tick();
      check_eq("frz_hold", dec_inst, I_ADD);
      check_eq("frz_iss", iss_valid, 0);
      rdy = 1; rob_full = 1; iq_valid = 0;
      tick();
      check_eq("stall_hold", dec_inst, I_ADD);
      #2 rst = 1;
      #1;
      check_eq("arst_inst", dec_inst, 0);
      check_eq("arst_drop_cnt", drop_cnt, 0);
      check_eq("arst_iss", iss_valid, 0);
      rst = 0; rob_full = 0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
